// File: rtl/fpul_mul_arbiter.sv
// fpul_mul_arbiter
//   Shares one external combinational multiplier between two requesters
//   (A and B). A round-robin arbiter picks one valid request per cycle and
//   registers its operands onto the multiplier inputs (stage 1). The
//   multiplier result is sampled with the owner tag in stage 2. It then
//   travels through a fixed-length delay line up to stage LAT, which is the
//   response stage. The response is a one-cycle rvalid pulse to the owner.
//
//   LAT (2..6) is the number of cycles from the acceptance edge to the
//   visible response.
//   stall freezes everything and masks the response pulse. The pulse is
//   delivered in the first cycle after stall drops.
//
//   Optional build macro: FPUL_MUL_ARB_ZERO_BYPASS_EN
//     When defined, stage 2 replaces the multiplier result with a signed
//     zero if either registered operand has a zero exponent field. This
//     covers the multiplier's missing zero/denormal handling.
module fpul_mul_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        a_valid,
  input  logic [31:0] a_srca,
  input  logic [31:0] a_srcb,
  output logic        a_ready,
  output logic        a_rvalid,
  output logic [31:0] a_dst,
  input  logic        b_valid,
  input  logic [31:0] b_srca,
  input  logic [31:0] b_srcb,
  output logic        b_ready,
  output logic        b_rvalid,
  output logic [31:0] b_dst,
  output logic [31:0] mul_srca,
  output logic [31:0] mul_srcb,
  input  logic [31:0] mul_dst
);

  // Round-robin pointer: names the requester that wins when both are valid.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

  // Owner tag values carried down the pipeline.
  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  rr_ptr_e     ptr_r;
  logic        grant_a_s;
  logic        grant_b_s;

  // Stage 1: operand registers are the mul_srca/mul_srcb ports themselves.
  logic        s1_v_r;
  logic        s1_tag_r;

  // Value that stage 2 captures (the multiplier result, optionally bypassed).
  logic [31:0] stage2_res_s;

  // Input of the response stage (stage LAT).
  logic        in_v_s;
  logic        in_tag_s;
  logic [31:0] in_res_s;

  // Response stage valid/tag. a_dst/b_dst hold that stage's result per owner.
  logic        out_v_r;
  logic        out_tag_r;

`ifdef FPUL_MUL_ARB_ZERO_BYPASS_EN
  // Signed zero when either operand has a zero exponent, else the multiplier result.
  function automatic logic [31:0] zero_bypass(
    input logic [31:0] srca,
    input logic [31:0] srcb,
    input logic [31:0] prod
  );
    logic [31:0] res;
    if ((srca[30:23] == 8'h00) || (srcb[30:23] == 8'h00)) begin
      res = {srca[31] ^ srcb[31], 31'h0000_0000};
    end else begin
      res = prod;
    end
    return res;
  endfunction
`endif

  // Arbitration: combinational grant from the valids, stall, reset and the pointer.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (reset || stall) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid && b_valid) begin
      case (ptr_r)
        PTR_A:   grant_a_s = 1'b1;
        PTR_B:   grant_b_s = 1'b1;
        default: grant_a_s = 1'b1;
      endcase
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else if (b_valid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Stage 1: load the winner's operands and tag. The pointer moves away from the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_srca <= 32'h0000_0000;
      mul_srcb <= 32'h0000_0000;
      s1_v_r   <= 1'b0;
      s1_tag_r <= TAG_A;
      ptr_r    <= PTR_A;
    end else if (!stall) begin
      if (grant_a_s) begin
        mul_srca <= a_srca;
        mul_srcb <= a_srcb;
        s1_v_r   <= 1'b1;
        s1_tag_r <= TAG_A;
        ptr_r    <= PTR_B;
      end else if (grant_b_s) begin
        mul_srca <= b_srca;
        mul_srcb <= b_srcb;
        s1_v_r   <= 1'b1;
        s1_tag_r <= TAG_B;
        ptr_r    <= PTR_A;
      end else begin
        // Bubble: operands and pointer keep their old values.
        s1_v_r   <= 1'b0;
      end
    end
  end

  // Stage 2 sample value: the multiplier result, with optional zero bypass.
  always_comb begin
`ifdef FPUL_MUL_ARB_ZERO_BYPASS_EN
    stage2_res_s = zero_bypass(mul_srca, mul_srcb, mul_dst);
`else
    stage2_res_s = mul_dst;
`endif
  end

  generate
    if (LAT <= 2) begin : g_direct
      // Stage 2 is the response stage, so it samples the multiplier directly.
      assign in_v_s   = s1_v_r;
      assign in_tag_s = s1_tag_r;
      assign in_res_s = stage2_res_s;
    end else begin : g_delay
      // Stages 2..LAT-1: result/tag delay registers ahead of the response stage.
      logic [LAT-1:2] dly_v_r;
      logic [LAT-1:2] dly_tag_r;
      logic [31:0]    dly_res_r [2:LAT-1];

      // Delay line: stage 2 samples the multiplier, later stages shift. Holds on stall.
      always_ff @(posedge clk) begin
        if (reset) begin
          dly_v_r   <= {(LAT-2){1'b0}};
          dly_tag_r <= {(LAT-2){1'b0}};
          for (int s = 2; s <= LAT - 1; s++) begin
            dly_res_r[s] <= 32'h0000_0000;
          end
        end else if (!stall) begin
          dly_v_r[2]   <= s1_v_r;
          dly_tag_r[2] <= s1_tag_r;
          dly_res_r[2] <= stage2_res_s;
          for (int s = 3; s <= LAT - 1; s++) begin
            dly_v_r[s]   <= dly_v_r[s-1];
            dly_tag_r[s] <= dly_tag_r[s-1];
            dly_res_r[s] <= dly_res_r[s-1];
          end
        end
      end

      assign in_v_s   = dly_v_r[LAT-1];
      assign in_tag_s = dly_tag_r[LAT-1];
      assign in_res_s = dly_res_r[LAT-1];
    end
  endgenerate

  // Response stage: capture valid/tag. Only the owner's dst register updates, so the other holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_r   <= 1'b0;
      out_tag_r <= TAG_A;
      a_dst     <= 32'h0000_0000;
      b_dst     <= 32'h0000_0000;
    end else if (!stall) begin
      out_v_r   <= in_v_s;
      out_tag_r <= in_tag_s;
      if (in_v_s && (in_tag_s == TAG_A)) begin
        a_dst <= in_res_s;
      end
      if (in_v_s && (in_tag_s == TAG_B)) begin
        b_dst <= in_res_s;
      end
    end
  end

  // Pulses are masked while frozen. The held response stage re-presents the pulse once stall drops.
  assign a_rvalid = out_v_r & (out_tag_r == TAG_A) & ~stall & ~reset;
  assign b_rvalid = out_v_r & (out_tag_r == TAG_B) & ~stall & ~reset;

endmodule

// File: tb/tb_fpul_mul_arbiter.sv
// Bench for fpul_mul_arbiter. A stub multiplier (sum of operands) is attached.
// A transaction-level model tracks the arbitration pointer and keeps a queue of
// accepted operations with their count of elapsed unfrozen edges.
module tb_fpul_mul_arbiter;
  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        a_valid, b_valid;
  logic [31:0] a_srca, a_srcb, b_srca, b_srcb;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [31:0] a_dst, b_dst, mul_srca, mul_srcb, mul_dst;

  int n_tests = 0;
  int n_fail  = 0;

  fpul_mul_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .a_valid(a_valid), .a_srca(a_srca), .a_srcb(a_srcb),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_dst(a_dst),
    .b_valid(b_valid), .b_srca(b_srca), .b_srcb(b_srcb),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_dst(b_dst),
    .mul_srca(mul_srca), .mul_srcb(mul_srcb), .mul_dst(mul_dst)
  );

  // Stub multiplier: combinational sum.
  assign mul_dst = mul_srca + mul_srcb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          tag;   // 0 = A, 1 = B
    logic [31:0] val;
    int          cnt;   // unfrozen edges since (and including) the accept edge
  } op_t;

  op_t q[$];
  bit  m_ptr;           // 0 = A preferred

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [31:0] x, input logic [31:0] y);
`ifdef FPUL_MUL_ARB_ZERO_BYPASS_EN
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {x[31] ^ y[31], 31'h0};
`endif
    return x + y;
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance the model at posedge.
  task automatic step(input bit rst, input bit st,
                      input bit av, input logic [31:0] aa, input logic [31:0] ab,
                      input bit bv, input logic [31:0] ba, input logic [31:0] bb);
    bit ga, gb, ear, ebr;
    logic [31:0] ead, ebd;
    reset = rst; stall = st;
    a_valid = av; a_srca = aa; a_srcb = ab;
    b_valid = bv; b_srca = ba; b_srcb = bb;
    @(negedge clk);
    ga = 1'b0; gb = 1'b0;
    if (!rst && !st) begin
      if (av && bv) begin ga = (m_ptr == 1'b0); gb = !ga; end
      else begin ga = av; gb = bv; end
    end
    check_eq("a_ready", {31'h0, a_ready}, {31'h0, ga});
    check_eq("b_ready", {31'h0, b_ready}, {31'h0, gb});
    ear = 1'b0; ebr = 1'b0; ead = 32'h0; ebd = 32'h0;
    if (!rst && !st) begin
      foreach (q[i]) begin
        if (q[i].cnt == LAT) begin
          if (q[i].tag) begin ebr = 1'b1; ebd = q[i].val; end
          else begin ear = 1'b1; ead = q[i].val; end
        end
      end
    end
    check_eq("a_rvalid", {31'h0, a_rvalid}, {31'h0, ear});
    check_eq("b_rvalid", {31'h0, b_rvalid}, {31'h0, ebr});
    if (ear) check_eq("a_dst", a_dst, ead);
    if (ebr) check_eq("b_dst", b_dst, ebd);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr = 1'b0;
    end else if (!st) begin
      foreach (q[i]) q[i].cnt = q[i].cnt + 1;
      while (q.size() > 0 && q[0].cnt > LAT) void'(q.pop_front());
      if (ga) begin
        q.push_back('{tag: 1'b0, val: model_result(aa, ab), cnt: 1});
        m_ptr = 1'b1;
      end else if (gb) begin
        q.push_back('{tag: 1'b1, val: model_result(ba, bb), cnt: 1});
        m_ptr = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r[30:23] = 8'h00;
    return r;
  endfunction

  initial begin
    logic [31:0] exp_zb;
    m_ptr = 1'b0;
    // Reset and reset-state checks.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check_eq("rst_mul_srca", mul_srca, 32'h0);
    check_eq("rst_mul_srcb", mul_srcb, 32'h0);
    check_eq("rst_a_dst", a_dst, 32'h0);
    check_eq("rst_b_dst", b_dst, 32'h0);

    // Single A request; the response pulse arrives two cycles later.
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 32'h0, 32'h0);
    idle(3);
    check_eq("single_a_dst", a_dst, 32'h8040_0000);
    check_eq("single_b_dst", b_dst, 32'h0);

    // Both valid for 6 cycles: grants alternate.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1, 32'h100 + i, 32'h10, 1'b1, 32'h200 + i, 32'h20);
    idle(3);

    // Only B for 3 cycles, then both: A must win first.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h30 + i, 32'h3);
    step(1'b0, 1'b0, 1'b1, 32'h55, 32'h5, 1'b1, 32'h66, 32'h6);
    idle(3);

    // Stall for 3 cycles while an op sits in stage 2; B requests are ignored while frozen.
    step(1'b0, 1'b0, 1'b1, 32'h1234, 32'h1111, 1'b0, 32'h0, 32'h0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'h9, 32'h9, 1'b1, 32'h8, 32'h8);
    idle(3);

    // Reset right after acceptance: the op is discarded, and A wins next.
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h7777, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 32'hA, 32'hA, 1'b1, 32'hB, 32'hB);
    idle(3);

    // Zero-exponent operand.
`ifdef FPUL_MUL_ARB_ZERO_BYPASS_EN
    exp_zb = 32'h8000_0000;
`else
    exp_zb = 32'hC040_0000;
`endif
    step(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h4040_0000, 1'b0, 32'h0, 32'h0);
    idle(3);
    check_eq("zero_exp_a_dst", a_dst, exp_zb);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) < 7, rand_op(), rand_op(),
           $urandom_range(0, 9) < 7, rand_op(), rand_op());
    end
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
